// File: rtl/tlm_fifo.sv
// tlm_fifo - synchronous first-in first-out buffer with valid/ready handshakes
// on both sides, in the style of a TLM put_export/get_export channel.
//
// Parameters:
//   WIDTH  bit width of each stored transaction (default 32)
//   DEPTH  number of storage entries, any integer >= 1 (default 3)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   put_valid  producer offers put_data
//   put_ready  FIFO can accept an entry (= !full)
//   put_data   transaction written on a put handshake
//   get_valid  get_data holds the oldest entry (= !empty)
//   get_ready  consumer takes the oldest entry
//   get_data   oldest stored transaction
//   count      current number of stored entries
//   full       count == DEPTH
//   empty      count == 0
//   overflow   sticky: put_valid seen while full (only with TLM_FIFO_ERR_EN)
//   underflow  sticky: get_ready seen while empty (only with TLM_FIFO_ERR_EN)
//
// Configuration macro:
//   TLM_FIFO_ERR_EN  adds the overflow/underflow sticky error flags.
//   Without it those ports and their logic do not exist.

module tlm_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         put_valid,
  output logic                         put_ready,
  input  logic [WIDTH-1:0]             put_data,
  output logic                         get_valid,
  input  logic                         get_ready,
  output logic [WIDTH-1:0]             get_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
`ifdef TLM_FIFO_ERR_EN
  ,
  output logic                         overflow,
  output logic                         underflow
`endif
);

  // Pointer width is kept at least one bit so DEPTH=1 still elaborates.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             put_hs;
  logic             get_hs;

  // Status flags depend only on the registered count, so put_ready never
  // looks at get_ready and a full FIFO refuses a put even while draining.
  always_comb begin
    full      = (count == FULL_COUNT);
    empty     = (count == '0);
    put_ready = !full;
    get_valid = !empty;
    put_hs    = put_valid && put_ready;
    get_hs    = get_valid && get_ready;
  end

  // The head entry is read straight from storage; there is no bypass from
  // put_data, so a freshly written entry appears one cycle after its put.
  assign get_data = mem[rd_ptr];

  // Storage is intentionally not reset: after reset the pointers and count
  // make any stale contents unreachable.
  always_ff @(posedge clk) begin
    if (put_hs) begin
      mem[wr_ptr] <= put_data;
    end
  end

  // Pointers wrap explicitly at DEPTH-1 because DEPTH need not be a power
  // of two. Count moves only on put-only or get-only cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (put_hs) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      end
      if (get_hs) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      end
      case ({put_hs, get_hs})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef TLM_FIFO_ERR_EN
  // Sticky error flags: set on an illegal request, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (put_valid && full) begin
        overflow <= 1'b1;
      end
      if (get_ready && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tlm_fifo.sv
// tb_tlm_fifo - directed self-checking bench for tlm_fifo (DEPTH=3, WIDTH=32).
// Inputs change 1 ns after each rising edge and outputs are sampled at the
// same point, away from the active edge.

module tb_tlm_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             put_valid;
  logic             put_ready;
  logic [WIDTH-1:0] put_data;
  logic             get_valid;
  logic             get_ready;
  logic [WIDTH-1:0] get_data;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
`ifdef TLM_FIFO_ERR_EN
  logic             overflow;
  logic             underflow;
`endif

  int tests_run;
  int tests_failed;

  tlm_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .put_valid (put_valid),
    .put_ready (put_ready),
    .put_data  (put_data),
    .get_valid (get_valid),
    .get_ready (get_ready),
    .get_data  (get_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
`ifdef TLM_FIFO_ERR_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Put one entry with get_ready low.
  task automatic put_one(input logic [WIDTH-1:0] d);
    put_valid = 1'b1;
    put_data  = d;
    get_ready = 1'b0;
    step();
    put_valid = 1'b0;
  endtask

  task automatic apply_reset();
    put_valid = 1'b0;
    get_ready = 1'b0;
    put_data  = '0;
    rst_n     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    step();
    tests_run++;
    if (count !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_count: got %0d expected 0", count);
    end
    tests_run++;
    if (empty !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_empty: got %b expected 1", empty);
    end
    tests_run++;
    if (full !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_full: got %b expected 0", full);
    end
    tests_run++;
    if (put_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_put_ready: got %b expected 1", put_ready);
    end
    tests_run++;
    if (get_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_get_valid: got %b expected 0", get_valid);
    end
  endtask

  task automatic test_fill_drain();
    logic [WIDTH-1:0] exp_data [3];
    exp_data[0] = 32'hA1;
    exp_data[1] = 32'hA2;
    exp_data[2] = 32'hA3;
    for (int i = 0; i < 3; i++) begin
      put_one(exp_data[i]);
      tests_run++;
      if (count !== CW'(i + 1)) begin
        tests_failed++;
        $display("[TB] FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1);
      end
    end
    tests_run++;
    if (full !== 1'b1 || put_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fill_full: got full=%b put_ready=%b expected full=1 put_ready=0",
               full, put_ready);
    end
    // get_ready held high for three cycles, checking each head before it leaves
    get_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (get_valid !== 1'b1 || get_data !== exp_data[i]) begin
        tests_failed++;
        $display("[TB] FAIL drain_data[%0d]: got valid=%b data=%0h expected valid=1 data=%0h",
                 i, get_valid, get_data, exp_data[i]);
      end
      step();
    end
    get_ready = 1'b0;
    tests_run++;
    if (empty !== 1'b1 || count !== 0) begin
      tests_failed++;
      $display("[TB] FAIL drain_empty: got empty=%b count=%0d expected empty=1 count=0",
               empty, count);
    end
  endtask

  task automatic test_empty_get();
    // get_ready on an empty FIFO must not disturb anything
    get_ready = 1'b1;
    step();
    step();
    get_ready = 1'b0;
    tests_run++;
    if (count !== 0 || empty !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL empty_get: got count=%0d empty=%b expected count=0 empty=1",
               count, empty);
    end
  endtask

  task automatic test_back_to_back();
    int nxt;
    int exp;
    int cyc;
    nxt       = 1;
    exp       = 1;
    cyc       = 0;
    put_valid = 1'b1;
    put_data  = 1;
    get_ready = 1'b1;
    while (exp <= 10 && cyc < 40) begin
      tests_run++;
      if (count > CW'(DEPTH)) begin
        tests_failed++;
        $display("[TB] FAIL stream_count: got %0d expected <= %0d", count, DEPTH);
      end
      if (get_valid) begin
        tests_run++;
        if (get_data !== WIDTH'(exp)) begin
          tests_failed++;
          $display("[TB] FAIL stream_data: got %0d expected %0d", get_data, exp);
        end
        exp++;
      end
      if (put_valid && put_ready) nxt++;
      step();
      cyc++;
      put_data  = WIDTH'(nxt);
      put_valid = (nxt <= 10);
    end
    put_valid = 1'b0;
    get_ready = 1'b0;
    tests_run++;
    if (exp != 11) begin
      tests_failed++;
      $display("[TB] FAIL stream_timeout: got %0d outputs expected 10", exp - 1);
    end
    tests_run++;
    if (empty !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL stream_empty: got %b expected 1", empty);
    end
  endtask

  task automatic test_full_put_get();
    put_one(32'hB1);
    put_one(32'hB2);
    put_one(32'hB3);
    put_valid = 1'b1;
    put_data  = 32'hB4;
    get_ready = 1'b1;
    tests_run++;
    if (put_ready !== 1'b0 || get_data !== 32'hB1) begin
      tests_failed++;
      $display("[TB] FAIL full_both_pre: got put_ready=%b data=%0h expected put_ready=0 data=b1",
               put_ready, get_data);
    end
    step();
    get_ready = 1'b0;
    tests_run++;
    if (count !== 2 || get_data !== 32'hB2) begin
      tests_failed++;
      $display("[TB] FAIL full_both_post: got count=%0d data=%0h expected count=2 data=b2",
               count, get_data);
    end
    step();
    put_valid = 1'b0;
    tests_run++;
    if (count !== 3) begin
      tests_failed++;
      $display("[TB] FAIL full_retry_put: got count=%0d expected 3", count);
    end
    get_ready = 1'b1;
    step();
    step();
    tests_run++;
    if (get_data !== 32'hB4 || count !== 1) begin
      tests_failed++;
      $display("[TB] FAIL full_order: got data=%0h count=%0d expected data=b4 count=1",
               get_data, count);
    end
    step();
    get_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    put_one(32'hC1);
    put_one(32'hC2);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (empty !== 1'b1 || count !== 0 || get_valid !== 1'b0 || put_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midreset_async: got empty=%b count=%0d get_valid=%b put_ready=%b expected 1/0/0/1",
               empty, count, get_valid, put_ready);
    end
    step();
    rst_n = 1'b1;
    step();
    put_one(32'hD1);
    tests_run++;
    if (count !== 1 || get_data !== 32'hD1) begin
      tests_failed++;
      $display("[TB] FAIL midreset_no_stale: got count=%0d data=%0h expected count=1 data=d1",
               count, get_data);
    end
    get_ready = 1'b1;
    step();
    get_ready = 1'b0;
  endtask

`ifdef TLM_FIFO_ERR_EN
  task automatic test_err_flags();
    apply_reset();
    tests_run++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL err_reset: got ovf=%b unf=%b expected 0/0", overflow, underflow);
    end
    get_ready = 1'b1;
    step();
    get_ready = 1'b0;
    tests_run++;
    if (underflow !== 1'b1 || overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL err_underflow: got ovf=%b unf=%b expected 0/1", overflow, underflow);
    end
    put_one(32'hE1);
    put_one(32'hE2);
    put_one(32'hE3);
    put_one(32'hE4);
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL err_overflow: got %b expected 1", overflow);
    end
    get_ready = 1'b1;
    step();
    step();
    step();
    get_ready = 1'b0;
    tests_run++;
    if (overflow !== 1'b1 || underflow !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL err_sticky: got ovf=%b unf=%b expected 1/1", overflow, underflow);
    end
    apply_reset();
    tests_run++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL err_clear: got ovf=%b unf=%b expected 0/0", overflow, underflow);
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    put_valid    = 1'b0;
    get_ready    = 1'b0;
    put_data     = '0;
    test_reset();
    test_fill_drain();
    test_empty_get();
    test_back_to_back();
    test_full_put_get();
    test_reset_mid();
`ifdef TLM_FIFO_ERR_EN
    test_err_flags();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tlm_fifo.md
TLM_FIFO -- requirements
Module: tlm_fifo

Interface
REQ-001 The parameter list SHALL be: WIDTH, default 32, bit width of each stored transaction.
REQ-002 The parameter list SHALL also include: DEPTH, default 3, number of storage entries (any integer >= 1, not restricted to powers of two).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be:
 clk  input  1  rising-edge clock
 rst_n  input  1  asynchronous active-low reset
 put_valid  input  1  producer offers put_data (put_export side)
 put_ready  output  1  FIFO can accept an entry
 put_data  input  WIDTH  transaction written on put handshake
 get_valid  output  1  get_data holds the oldest entry (get_export side)
 get_ready  input  1  consumer takes the oldest entry
 get_data  output  WIDTH  oldest stored transaction
 count  output  $clog2(DEPTH+1)  current number of stored entries
 full  output  1  count == DEPTH
 empty  output  1  count == 0

Function
REQ-005 A put handshake SHALL be put_valid && put_ready at a rising clk edge; the entry is stored at that edge.
REQ-006 A get handshake SHALL be get_valid && get_ready at a rising clk edge; the oldest entry is removed at that edge.
REQ-007 put_ready SHALL equal !full, combinationally from registered state only, with no dependence on get_ready.
REQ-008 get_valid SHALL equal !empty; get_data SHALL be driven from the storage entry at the read pointer, with no combinational path from put_data.
REQ-009 Ordering SHALL be strictly first-in first-out; no entry is dropped, duplicated or reordered.
REQ-010 Latency SHALL be one cycle: an entry put at edge N is visible on get_data with get_valid=1 after edge N when the FIFO was empty.
REQ-011 Read and write pointers SHALL each range over 0..DEPTH-1 and wrap from DEPTH-1 to 0.
REQ-012 Simultaneous put and get handshakes in one cycle SHALL leave count unchanged and advance both pointers.
REQ-013 When full, a simultaneous get SHALL still complete, but the put is not accepted in that cycle because put_ready is 0.
REQ-014 When empty, get_ready SHALL have no effect; get_data value is don't-care.
REQ-015 count SHALL increment on put-only cycles and decrement on get-only cycles; it SHALL never exceed DEPTH or go below 0.

Reset
REQ-016 Asserting rst_n low SHALL immediately clear pointers and count, giving empty=1, full=0, get_valid=0, put_ready=1 and count=0.
REQ-017 Reset asserted mid-operation SHALL discard all stored entries; storage contents need not be cleared.
REQ-018 The first handshake after reset SHALL occur no earlier than the first rising clk edge with rst_n high.

Configuration
REQ-019 With TLM_FIFO_ERR_EN defined, the block SHALL add ports overflow and underflow (output, 1 bit each).
REQ-020 overflow SHALL be a sticky flag set when put_valid=1 while full=1.
REQ-021 underflow SHALL be a sticky flag set when get_ready=1 while empty=1.
REQ-022 overflow and underflow SHALL be cleared only by reset.
REQ-023 Without TLM_FIFO_ERR_EN, the overflow and underflow ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-024 Reset, then hold idle -> count=0, empty=1, full=0, put_ready=1, get_valid=0.
REQ-025 DEPTH=3: put 0xA1, 0xA2, 0xA3 with get_ready=0 -> full=1, put_ready=0, count=3; then get three times -> data returned as 0xA1, 0xA2, 0xA3, then empty=1.
REQ-026 Stream 10 entries (1..10) with put_valid and get_ready held at 1 -> all outputs equal 1..10 in order; pointers wrap past 2 correctly; count never exceeds 3.
REQ-027 Full FIFO with put_valid=1 and get_ready=1 -> one entry leaves, none enters that cycle, count=2; next cycle the put is accepted.
REQ-028 Put 2 entries, then assert rst_n low between clock edges -> empty=1 and count=0 immediately; the old data is never returned.
REQ-029 With TLM_FIFO_ERR_EN defined: put_valid=1 while full -> overflow=1 and stays 1; get_ready=1 while empty -> underflow=1; both clear only on reset.
